// File: rtl/if_prefetch_pkg.sv
// Shared types and sizing helpers for the instruction prefetch buffer.
package if_prefetch_pkg;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] pcPlus4;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int out_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_flush.sv
// Registered FIFO of fetch entries; flush empties it and overrides push/pop.
module sync_fifo_flush
  import if_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = count_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  fetch_entry_t  i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || i_pop) && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/if_prefetch_buffer.sv
// Fetch-PC owner and prefetch queue feeding IF/ID; redirects flush the queue
// and squash responses of requests already in flight.
module if_prefetch_buffer
  import if_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirectValid,
  input  logic [31:0] redirectAdr,
  output logic        memReq,
  output logic [31:0] memAdr,
  input  logic        memGnt,
  input  logic        memRspValid,
  input  logic [31:0] memRspData,
  output logic        instValid,
  output logic [31:0] instruction,
  output logic [31:0] instPcPlus4,
  input  logic        instReady
);

  localparam int          CW   = count_w(DEPTH);
  localparam int          OW   = out_w(MAX_OUT);
  localparam logic [31:0] STEP = 32'(WORD_BYTES);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] r_discard;

  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  logic          w_credit_ok;
  logic          w_grant;
  logic          w_rsp_take;
  logic          w_push;
  logic          w_pop;
  logic [OW-1:0] w_out_after_rsp;
  logic [31:0]   w_redir_pc;

  // Credits count both queued entries and requests whose data is still coming.
  assign w_credit_ok = (int'(r_outstanding) < MAX_OUT) &&
                       ((int'(r_outstanding) + int'(w_count)) < DEPTH);
  assign memReq      = !rst && !redirectValid && w_credit_ok;
  assign memAdr      = r_fetch_pc;
  assign w_grant     = memReq && memGnt;

  assign w_rsp_take      = memRspValid && (r_outstanding != '0);
  assign w_out_after_rsp = r_outstanding - OW'(w_rsp_take);
  assign w_push          = w_rsp_take && (r_discard == '0) && !redirectValid;
  assign w_push_data     = '{pcPlus4: r_rsp_pc + STEP, instr: memRspData};
  assign w_redir_pc      = redirectAdr & ~32'h3;

  assign instValid   = !w_empty && !redirectValid;
  assign instruction = w_empty ? '0 : w_head.instr;
  assign instPcPlus4 = w_empty ? '0 : w_head.pcPlus4;
  assign w_pop       = instValid && instReady;

  sync_fifo_flush #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (redirectValid),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirectValid) begin
      // Every request still in flight, squashed earlier or now, must be dropped.
      r_fetch_pc    <= w_redir_pc;
      r_rsp_pc      <= w_redir_pc;
      r_outstanding <= w_out_after_rsp;
      r_discard     <= w_out_after_rsp;
    end else begin
      if (w_grant) r_fetch_pc <= r_fetch_pc + STEP;
      if (w_push)  r_rsp_pc   <= r_rsp_pc + STEP;
      r_outstanding <= w_out_after_rsp + OW'(w_grant);
      if (w_rsp_take && (r_discard != '0)) r_discard <= r_discard - 1'b1;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_full && !w_pop));
  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (rst)
    !(memRspValid && (r_outstanding == '0)));

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Bench for if_prefetch_buffer: in-order variable-latency memory model,
// spec-level PC stream model, and an expected-entry scoreboard.
module tb_if_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectAdr = '0;
  logic        memReq;
  logic [31:0] memAdr;
  logic        memGnt = 1'b0;
  logic        memRspValid = 1'b0;
  logic [31:0] memRspData = '0;
  logic        instValid;
  logic [31:0] instruction;
  logic [31:0] instPcPlus4;
  logic        instReady = 1'b0;

  if_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirectValid (redirectValid),
    .redirectAdr   (redirectAdr),
    .memReq        (memReq),
    .memAdr        (memAdr),
    .memGnt        (memGnt),
    .memRspValid   (memRspValid),
    .memRspData    (memRspData),
    .instValid     (instValid),
    .instruction   (instruction),
    .instPcPlus4   (instPcPlus4),
    .instReady     (instReady)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] model_pc = RESET_PC;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_grant = 0;
  int          gnt_pct, ready_pct, lat_min, lat_max, redir_pct;
  logic        redir_now = 1'b0;
  logic [31:0] redir_target = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16] ^ a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_knobs(input int g, input int r, input int lmin, input int lmax, input int rd);
    gnt_pct = g; ready_pct = r; lat_min = lmin; lat_max = lmax; redir_pct = rd;
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       return r & 32'h0000_0FFF;
      1:       return 32'hFFFF_FFF0 | (r & 32'h0000_000F);
      default: return r;
    endcase
  endfunction

  // driver: applies this cycle's inputs 1 time unit after the active edge
  task automatic drive_inputs();
    memRspValid = (pend_q.size() != 0) && (pend_q[0].due <= cyc);
    memRspData  = memRspValid ? mem_word(pend_q[0].adr) : 32'h0;
    memGnt      = int'($urandom_range(0, 99)) < gnt_pct;
    instReady   = int'($urandom_range(0, 99)) < ready_pct;
    if (redir_now) begin
      redirectValid = 1'b1;
      redirectAdr   = redir_target;
      redir_now     = 1'b0;
    end else if (int'($urandom_range(0, 99)) < redir_pct) begin
      redirectValid = 1'b1;
      redirectAdr   = rand_target();
    end else begin
      redirectValid = 1'b0;
      redirectAdr   = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive_inputs();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    memGnt = 1'b0; memRspValid = 1'b0; memRspData = '0;
    instReady = 1'b0; redirectValid = 1'b0; redirectAdr = '0;
    #1;
    check("rst_req_valid", {62'b0, memReq, instValid}, 64'd0);
    check("rst_adr", {32'b0, memAdr}, {32'b0, RESET_PC});
    check("rst_data", {instPcPlus4, instruction}, 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    drive_inputs();
    #2;
  endtask

  // bus observer: memory model, fetch-address model, expected-entry producer
  initial forever begin
    @(negedge clk);
    if (rst) begin
      model_pc = RESET_PC;
      pend_q.delete();
      exp_q.delete();
    end else begin
      if (memRspValid && pend_q.size() != 0) void'(pend_q.pop_front());
      if (redirectValid) begin
        check("redir_quiet", {62'b0, memReq, instValid}, 64'd0);
        model_pc = {redirectAdr[31:2], 2'b00};
        exp_q.delete();
      end
      if (memReq && memGnt) begin
        check("fetch_adr", {32'b0, memAdr}, {32'b0, model_pc});
        pend_q.push_back('{adr: memAdr, due: cyc + int'($urandom_range(lat_min, lat_max))});
        exp_q.push_back({model_pc + 32'd4, mem_word(model_pc)});
        model_pc = model_pc + 32'd4;
        n_grant++;
      end
    end
  end

  // monitor: every accepted instruction must match the oldest expected entry
  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    if (!rst && instValid && instReady) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %h expected no entry (cycle %0d)",
                 {instPcPlus4, instruction}, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pop_entry", {instPcPlus4, instruction}, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;

    // streaming with a 1-cycle memory
    set_knobs(100, 100, 1, 1, 0);
    do_reset();
    check("c0_issue", {31'b0, memReq, memAdr}, {32'd1, RESET_PC});
    check("c0_valid", {63'b0, instValid}, 64'd0);
    step();
    check("c1_valid", {63'b0, instValid}, 64'd0);
    step();
    check("c2_head", {31'b0, instValid, instPcPlus4}, {32'd1, 32'd4});
    for (int k = 3; k < 10; k++) begin
      step();
      check("stream_valid", {63'b0, instValid}, 64'd1);
    end

    // consumer stalled: credits cap fetches at DEPTH
    set_knobs(100, 0, 1, 1, 0);
    do_reset();
    g0 = n_grant;
    repeat (12) step();
    check("stall_grants", 64'(n_grant - g0), 64'(DEPTH));
    check("stall_req_valid", {62'b0, memReq, instValid}, 64'd1);
    ready_pct = 100;
    for (int b = 0; b < 10 && !memReq; b++) step();
    check("resume_adr", {31'b0, memReq, memAdr}, {32'd1, 32'h10});
    repeat (6) step();

    // redirect with two requests in flight on a 3-cycle memory
    set_knobs(100, 100, 3, 3, 0);
    do_reset();
    g0 = n_grant;
    for (int b = 0; b < 20 && (n_grant - g0) < 3; b++) step();
    redir_target = 32'h40;
    redir_now = 1'b1;
    step();
    for (int b = 0; b < 20 && !instValid; b++) step();
    check("redir_first", {instPcPlus4, instruction}, {32'h44, mem_word(32'h40)});
    repeat (6) step();

    // redirect coinciding with a response and a pop; low address bits ignored
    set_knobs(100, 100, 1, 1, 0);
    do_reset();
    repeat (5) step();
    redir_target = 32'h102;
    redir_now = 1'b1;
    step();
    step();
    check("post_redir_empty", {63'b0, instValid}, 64'd0);
    check("post_redir_issue", {31'b0, memReq, memAdr}, {32'd1, 32'h100});
    for (int b = 0; b < 10 && !instValid; b++) step();
    check("post_redir_head", {31'b0, instValid, instPcPlus4}, {32'd1, 32'h104});

    // grant stall holds the address; a redirect retargets it
    set_knobs(100, 100, 1, 1, 0);
    do_reset();
    for (int b = 0; b < 20 && !(memReq && memAdr == 32'h1C); b++) step();
    gnt_pct = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("gnt_stall_adr", {31'b0, memReq, memAdr}, {32'd1, 32'h20});
    end
    redir_target = 32'h80;
    redir_now = 1'b1;
    step();
    step();
    check("stall_redir_adr", {31'b0, memReq, memAdr}, {32'd1, 32'h80});
    gnt_pct = 100;
    repeat (6) step();

    // reset in the middle of traffic
    set_knobs(100, 0, 3, 3, 0);
    do_reset();
    repeat (5) step();
    set_knobs(100, 100, 2, 2, 0);
    do_reset();
    check("rerun_issue", {31'b0, memReq, memAdr}, {32'd1, RESET_PC});
    repeat (10) step();

    // randomized traffic with redirects, including PC wrap targets
    set_knobs(70, 70, 1, 4, 5);
    do_reset();
    repeat (3000) step();

    // drain: everything fetched must have been delivered
    set_knobs(0, 100, 1, 4, 0);
    repeat (20) step();
    check("drain_exp_empty", 64'(exp_q.size()), 64'd0);
    check("drain_valid", {63'b0, instValid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
